// File: rtl/gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_vector_sequencer
// Description : Walks every input pattern of an N_IN-input combinational gate,
//               holds each pattern for SETTLE idle cycles plus one sample
//               cycle, and checks the sampled gate output against the EXPECT
//               truth table. Reports pass/fail, error count and the first
//               failing pattern.
// Ports       : clk        - clock, all state changes on rising edge
//               rst        - synchronous active-high reset
//               start      - begin a sweep (accepted in IDLE or DONE only)
//               vec        - pattern driven to the gate under test
//               y_in       - gate output being checked
//               busy       - sweep in progress
//               done       - sweep finished, held until next start or rst
//               pass       - done and no mismatches
//               err_count  - number of mismatching patterns
//               fail_valid - at least one mismatch recorded this sweep
//               first_fail - index of the first mismatching pattern
// Revision    : 1.0 - initial release
// ============================================================================
module gate_vector_sequencer #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 2,
    parameter logic [2**N_IN-1:0]  EXPECT = 4'b1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int CNT_W    = ($clog2(SETTLE + 1) > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int RELOAD_I = (SETTLE > 0) ? (SETTLE - 1) : 0;
    localparam logic [CNT_W-1:0] c_cnt_reload = RELOAD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] c_cnt_one    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0]  c_idx_one    = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]    c_err_one    = {{N_IN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // With no settle window a pattern is sampled in its first cycle.
    localparam state_t c_first_state = (SETTLE > 0) ? S_HOLD : S_SAMPLE;

    state_t          r_state, w_state_nxt;
    logic [N_IN-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_IN:0]   r_err, w_err_nxt;
    logic            r_fv, w_fv_nxt;
    logic [N_IN-1:0] r_ff, w_ff_nxt;
    logic            w_mismatch;

    // Case inequality so an X/Z gate output is flagged in simulation.
    assign w_mismatch = (y_in !== EXPECT[r_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_ff    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_fv    <= w_fv_nxt;
            r_ff    <= w_ff_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fv_nxt    = r_fv;
        w_ff_nxt    = r_ff;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fv_nxt    = 1'b0;
                    w_ff_nxt    = '0;
                    w_cnt_nxt   = c_cnt_reload;
                    w_state_nxt = c_first_state;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + c_err_one;
                    if (!r_fv) begin
                        w_fv_nxt = 1'b1;
                        w_ff_nxt = r_idx;
                    end
                end
                if (&r_idx) begin
                    // vec keeps the last pattern while parked in DONE.
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + c_idx_one;
                    w_cnt_nxt   = c_cnt_reload;
                    w_state_nxt = c_first_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign vec        = r_idx;
    assign busy       = (r_state == S_HOLD) || (r_state == S_SAMPLE);
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_valid = r_fv;
    assign first_fail = r_ff;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_vector_sequencer
// Description : Directed bench for gate_vector_sequencer. A default-parameter
//               instance checks AND / stuck-0 / OR gates, restart and reset
//               behaviour; a SETTLE=0 instance checks the back-to-back sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] vec;
    logic       y_in;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail;

    logic       start0 = 1'b0;
    logic [1:0] vec0;
    logic       y_in0;
    logic       busy0, done0, pass0, fail_valid0;
    logic [2:0] err_count0;
    logic [1:0] first_fail0;

    int mode = 0;   // 0: AND gate, 1: output stuck at 0, 2: OR gate
    int errors = 0;
    int checks = 0;

    localparam logic [3:0] c_expect_tt = 4'b1000;

    assign y_in  = (mode == 0) ? (vec[1] & vec[0]) :
                   (mode == 1) ? 1'b0 : (vec[1] | vec[0]);
    assign y_in0 = vec0[1] & vec0[0];

    gate_vector_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .vec(vec), .y_in(y_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );

    gate_vector_sequencer #(.N_IN(2), .SETTLE(0), .EXPECT(4'b1000)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .vec(vec0), .y_in(y_in0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .fail_valid(fail_valid0), .first_fail(first_fail0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err;
        int ff;
        int fv;
        int ps;
    } exp_t;
    exp_t sb[$];

    function automatic logic model_gate(input int m, input int p);
        case (m)
            0:       return (p == 3);
            1:       return 1'b0;
            default: return (p != 0);
        endcase
    endfunction

    task automatic push_expected(input int m);
        exp_t e;
        e.err = 0; e.ff = 0; e.fv = 0;
        for (int p = 0; p < 4; p++) begin
            if (model_gate(m, p) != c_expect_tt[p]) begin
                if (e.fv == 0) begin
                    e.ff = p;
                    e.fv = 1;
                end
                e.err++;
            end
        end
        e.ps = (e.err == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a sweep on the default instance, checks vec/busy each cycle,
    // optionally pulses start again at cycle restart_at, then compares the
    // final status against the scoreboard entry.
    task automatic run_sweep(input int m, input int restart_at);
        exp_t e;
        int   lat;
        bit   got;
        mode = m;
        push_expected(m);
        @(negedge clk);
        start = 1'b1;
        got = 0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = (restart_at != 0) && (n == restart_at);
            if (done) begin
                lat = n - 1;
                got = 1;
                break;
            end
            if (n == 1) begin
                check("cleared_err", 32'(err_count), 0);
                check("cleared_fv", 32'(fail_valid), 0);
            end
            check("vec_step", 32'(vec), 32'((n - 1) / 3));
            check("busy_sweep", 32'(busy), 1);
        end
        start = 1'b0;
        if (!got) check("done_timeout", 0, 1);
        e = sb.pop_front();
        check("latency", 32'(lat), 12);
        check("err_count", 32'(err_count), 32'(e.err));
        check("fail_valid", 32'(fail_valid), 32'(e.fv));
        if (e.fv != 0) check("first_fail", 32'(first_fail), 32'(e.ff));
        check("pass", 32'(pass), 32'(e.ps));
        check("busy_done", 32'(busy), 0);
        check("vec_last", 32'(vec), 3);
    endtask

    initial begin
        int  lat0;
        bit  got0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vec", 32'(vec), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fv", 32'(fail_valid), 0);
        check("rst_ff", 32'(first_fail), 0);
        rst = 1'b0;

        // AND gate: clean sweep
        run_sweep(0, 0);
        repeat (3) @(negedge clk);
        check("done_held", 32'(done), 1);

        // Stuck-at-0 output: one error at pattern 3, started from DONE
        run_sweep(1, 0);
        // Second identical sweep from DONE, counters must clear first
        run_sweep(1, 0);

        // OR gate: errors at patterns 1 and 2, with an ignored mid-sweep start
        run_sweep(2, 4);

        // Reset mid-sweep while vec=10
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_vec", 32'(vec), 2);
        check("pre_rst_err", 32'(err_count), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vec", 32'(vec), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_err", 32'(err_count), 0);
        run_sweep(0, 0);

        // SETTLE=0 instance: one pattern per cycle
        @(negedge clk);
        start0 = 1'b1;
        got0 = 0;
        lat0 = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0) begin
                lat0 = n - 1;
                got0 = 1;
                break;
            end
            check("s0_vec_step", 32'(vec0), 32'(n - 1));
        end
        if (!got0) check("s0_done_timeout", 0, 1);
        check("s0_latency", 32'(lat0), 4);
        check("s0_pass", 32'(pass0), 1);
        check("s0_err", 32'(err_count0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Synchronous stimulus/checker stage that sits directly upstream of a 2-input combinational gate such as and_gate. It drives every input pattern onto the gate, holds each pattern for a settle window, and samples the gate output. It then compares the sample against a parameterised expected truth table and reports the pass/fail result, the error count and the first failing pattern. It replaces hand-written per-gate truth-table benches with one reusable, cycle-deterministic block.

Parameters:
N_IN, 2, number of gate inputs; the block walks 2**N_IN patterns.
SETTLE, 2, idle cycles each pattern is held before its sample cycle (0 allowed).
EXPECT, 4'b1000, expected truth table, width 2**N_IN. Bit i is the expected output for pattern i. The default is AND.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
vec  output  N_IN  pattern driven to the gate under test. For N_IN=2, vec[1]=a and vec[0]=b.
y_in  input  1  gate output being checked.
busy  output  1  high while a sweep is in progress.
done  output  1  high in DONE; held until the next start or rst.
pass  output  1  valid when done=1; equals (err_count==0).
err_count  output  N_IN+1  number of mismatching patterns.
fail_valid  output  1  at least one mismatch has been recorded in this sweep.
first_fail  output  N_IN  index of the first mismatching pattern; valid when fail_valid=1.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-sweep): next state is IDLE.
  - vec=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0.
  - rst has priority over start.
- States: IDLE, HOLD, SAMPLE, DONE. An internal pattern index idx (N_IN bits) and a settle counter cnt (clog2(SETTLE+1) bits, minimum 1) are kept.
- IDLE: busy=0, done=0. On start=1:
  - clear err_count, fail_valid and first_fail; set idx=0 and vec=0;
  - go to HOLD with cnt=SETTLE-1 if SETTLE>0, otherwise go directly to SAMPLE.
- HOLD: busy=1, vec=idx. cnt decrements each cycle; when cnt==0 go to SAMPLE.
- SAMPLE: busy=1, vec=idx. y_in is sampled at the end of this cycle.
  - A mismatch is y_in != EXPECT[idx]. X/Z on y_in counts as a mismatch in simulation.
  - On a mismatch: err_count increments; if fail_valid==0, set first_fail=idx and fail_valid=1.
  - If idx==2**N_IN-1, go to DONE. Otherwise idx increments, vec follows, and the block returns to HOLD (cnt reloaded) or, if SETTLE=0, to SAMPLE.
- vec changes only on the edge entering the first cycle of a pattern. Each pattern is held for exactly SETTLE+1 cycles, with no glitch cycle between patterns.
- DONE: busy=0, done=1, pass=(err_count==0), and vec holds the last pattern. A start in DONE behaves as a start in IDLE: counters are cleared, done drops the next cycle, and a new sweep begins.
- start during HOLD or SAMPLE is ignored. A start held high continuously therefore restarts a sweep only after DONE.
- Latency: if start is sampled at edge E, done is first high after edge E + 2**N_IN*(SETTLE+1). With the defaults this is 12 edges.
- err_count does not wrap, because its maximum is 2**N_IN and it fits in N_IN+1 bits.

Test Plan:
- Default parameters, y_in driven by an AND of vec[1], vec[0]; pulse start -> vec steps 00, 01, 10, 11, each held 3 cycles. done rises 12 edges after start with pass=1, err_count=0, fail_valid=0.
- y_in tied to 0 -> err_count=1, first_fail=3, fail_valid=1, pass=0.
- y_in driven by OR of the inputs, with EXPECT=4'b1000 -> err_count=2 (patterns 1 and 2), first_fail=1, pass=0.
- start pulsed again mid-sweep at pattern 1 -> ignored and the sweep finishes at edge 12. start pulsed in DONE -> done=0 the next cycle, counters cleared, and the second sweep gives an identical result.
- rst asserted for one cycle while vec=10 -> next cycle shows IDLE with vec=00, busy=0, done=0, err_count=0. A following start runs a full 12-edge sweep.
- SETTLE=0 with an AND DUT -> vec changes every cycle, done is high 4 edges after start, and pass=1.
